// File: rtl/gotchi_pkg.sv
// Shared constants and state encodings for the EngiGotchi sprite display path.
package gotchi_pkg;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned SPRITE_PIX = 16;

  localparam int unsigned CLR_LAST = SCREEN_W * SCREEN_H - 1;
  localparam int unsigned PIX_LAST = SPRITE_PIX - 1;

  localparam int unsigned CLR_W   = 15;
  localparam int unsigned PIX_W   = 5;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_DRAW  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ERASE = 3'd4,
    ST_MOVE  = 3'd5
  } state_e;

endpackage

// File: rtl/step_counter.sv
// Loadable up-counter that flags when it sits on its terminal value.
module step_counter #(
  parameter int unsigned W    = 8,
  parameter int unsigned LAST = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] count_q, count_d;

  // Load to zero has priority over counting.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == W'(LAST));

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Frame sequencer for the sprite datapath: clear once, then erase/move/redraw per frame tick.
module sprite_anim_ctrl
  import gotchi_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               stop,
  input  logic               pause,
  input  logic               frame_tick,
  output logic               dp_reset,
  output logic               erase,
  output logic               plot_en,
  output logic               update,
  output logic               vga_write,
  output logic               busy,
  output logic               overrun,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  logic   dp_reset_q, dp_reset_d;
  logic   erase_q, erase_d;
  logic   plot_en_q, plot_en_d;
  logic   update_q, update_d;
  logic   vga_write_q, vga_write_d;
  logic   busy_q, busy_d;
  logic   overrun_q, overrun_d;
  logic   clr_en, pix_en, clr_tc, pix_tc, busy_now;

  // Counters run only in their own states and sit at zero otherwise, so entry always starts at 0.
  assign clr_en   = (state_q == ST_CLEAR);
  assign pix_en   = (state_q == ST_DRAW) || (state_q == ST_ERASE);
  assign busy_now = (state_q == ST_CLEAR) || (state_q == ST_DRAW) ||
                    (state_q == ST_ERASE) || (state_q == ST_MOVE);

  step_counter #(.W(CLR_W), .LAST(CLR_LAST)) u_clr_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (!clr_en),
    .en_i   (clr_en),
    .tc_o   (clr_tc)
  );

  step_counter #(.W(PIX_W), .LAST(PIX_LAST)) u_pix_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (!pix_en),
    .en_i   (pix_en),
    .tc_o   (pix_tc)
  );

  // Next state, sticky overrun, and Moore strobes decoded from the next state so they register in step.
  always_comb begin
    state_d     = state_q;
    dp_reset_d  = 1'b0;
    erase_d     = 1'b0;
    plot_en_d   = 1'b0;
    update_d    = 1'b0;
    vga_write_d = 1'b0;
    busy_d      = 1'b0;
    overrun_d   = overrun_q | (frame_tick & busy_now);

    case (state_q)
      ST_IDLE:  if (go) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_tc) state_d = ST_DRAW;
      ST_DRAW:  if (pix_tc) state_d = ST_WAIT;
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (frame_tick && !pause) begin
          state_d = ST_ERASE;
        end
      end
      ST_ERASE: if (pix_tc) state_d = ST_MOVE;
      ST_MOVE:  state_d = ST_DRAW;
      default:  state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_IDLE:  dp_reset_d = 1'b1;
      ST_CLEAR: begin
        erase_d     = 1'b1;
        vga_write_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_DRAW: begin
        plot_en_d   = 1'b1;
        vga_write_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_ERASE: begin
        plot_en_d   = 1'b1;
        erase_d     = 1'b1;
        vga_write_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_MOVE: begin
        update_d = 1'b1;
        busy_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, strobe and overrun registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dp_reset_q  <= 1'b1;
      erase_q     <= 1'b0;
      plot_en_q   <= 1'b0;
      update_q    <= 1'b0;
      vga_write_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_reset_q  <= dp_reset_d;
      erase_q     <= erase_d;
      plot_en_q   <= plot_en_d;
      update_q    <= update_d;
      vga_write_q <= vga_write_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dp_reset  = dp_reset_q;
  assign erase     = erase_q;
  assign plot_en   = plot_en_q;
  assign update    = update_q;
  assign vga_write = vga_write_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl: vector table plus multi-cycle duration sequences.
module tb_sprite_anim_ctrl;

  logic       clk = 1'b0;
  logic       reset, go, stop, pause, frame_tick;
  logic       dp_reset, erase, plot_en, update, vga_write, busy, overrun;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sprite_anim_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .stop       (stop),
    .pause      (pause),
    .frame_tick (frame_tick),
    .dp_reset   (dp_reset),
    .erase      (erase),
    .plot_en    (plot_en),
    .update     (update),
    .vga_write  (vga_write),
    .busy       (busy),
    .overrun    (overrun),
    .state      (state)
  );

  // {state, dp_reset, erase, plot_en, update, vga_write, busy}
  localparam logic [8:0] O_IDLE  = {3'd0, 6'b100000};
  localparam logic [8:0] O_CLEAR = {3'd1, 6'b010011};
  localparam logic [8:0] O_DRAW  = {3'd2, 6'b001011};
  localparam logic [8:0] O_WAIT  = {3'd3, 6'b000000};
  localparam logic [8:0] O_ERASE = {3'd4, 6'b011011};
  localparam logic [8:0] O_MOVE  = {3'd5, 6'b000101};

  typedef struct {
    string       name;
    logic        rst;
    logic        go;
    logic        stop;
    logic        pause;
    logic        tick;
    int unsigned idle;
    logic [8:0]  exp_out;
    logic        exp_ov;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic logic [9:0] outs();
    return {state, dp_reset, erase, plot_en, update, vga_write, busy, overrun};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; go = v.go; stop = v.stop; pause = v.pause; frame_tick = v.tick;
    tick_clk();
    reset = 1'b0; go = 1'b0; stop = 1'b0; pause = 1'b0; frame_tick = 1'b0;
    for (int i = 0; i < int'(v.idle); i++) tick_clk();
  endtask

  // Start-up from IDLE, optionally poking stop in CLEAR and go in DRAW.
  task automatic run_start(input bit inject);
    int n_clr, n_draw, bad;
    n_clr = 0; n_draw = 0; bad = 0;
    go = 1'b1;
    tick_clk();
    go = 1'b0;
    while (state == 3'd1 && n_clr < 20000) begin
      if (!(erase && vga_write && busy && !plot_en)) bad++;
      n_clr++;
      stop = inject && (n_clr == 100);
      tick_clk();
      stop = 1'b0;
    end
    while (state == 3'd2 && n_draw < 100) begin
      if (!(plot_en && vga_write && busy && !erase)) bad++;
      n_draw++;
      go = inject && (n_draw == 3);
      tick_clk();
      go = 1'b0;
    end
    check("start_clear_cycles", n_clr, 19200);
    check("start_draw_cycles", n_draw, 16);
    check("start_strobes_bad", bad, 0);
    check("start_wait_state", int'(state), 3);
    check("start_wait_busy", int'(busy), 0);
  endtask

  // One accepted frame tick from WAIT, then a second tick at the minimum spacing.
  task automatic run_frame();
    int n_er, n_up, n_dr;
    n_er = 0; n_up = 0; n_dr = 0;
    frame_tick = 1'b1;
    tick_clk();
    frame_tick = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (state == 3'd4 && erase && plot_en && vga_write) n_er++;
      if (update) n_up++;
      if (state == 3'd2 && plot_en && vga_write && !erase) n_dr++;
      tick_clk();
    end
    check("frame_erase_cycles", n_er, 16);
    check("frame_update_pulses", n_up, 1);
    check("frame_draw_cycles", n_dr, 16);
    check("frame_back_wait", int'(state), 3);
    check("frame_overrun", int'(overrun), 0);
    frame_tick = 1'b1;
    tick_clk();
    frame_tick = 1'b0;
    check("spacing34_state", int'(state), 4);
    check("spacing34_overrun", int'(overrun), 0);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; stop = 1'b0; pause = 1'b0; frame_tick = 1'b0;

    vecs[0]  = '{"reset",          1, 0, 0, 0, 0, 0,     O_IDLE,  0};
    vecs[1]  = '{"go_clear",       0, 1, 0, 0, 0, 0,     O_CLEAR, 0};
    vecs[2]  = '{"clear_last",     0, 0, 0, 0, 0, 19198, O_CLEAR, 0};
    vecs[3]  = '{"draw_first",     0, 0, 0, 0, 0, 0,     O_DRAW,  0};
    vecs[4]  = '{"draw_last",      0, 0, 0, 0, 0, 14,    O_DRAW,  0};
    vecs[5]  = '{"wait_entry",     0, 0, 0, 0, 0, 0,     O_WAIT,  0};
    vecs[6]  = '{"pause_tick",     0, 0, 0, 1, 1, 0,     O_WAIT,  0};
    vecs[7]  = '{"tick_erase",     0, 0, 0, 0, 1, 0,     O_ERASE, 0};
    vecs[8]  = '{"tick_in_erase",  0, 0, 0, 0, 1, 14,    O_ERASE, 1};
    vecs[9]  = '{"move",           0, 0, 0, 0, 0, 0,     O_MOVE,  1};
    vecs[10] = '{"redraw_first",   0, 0, 0, 0, 0, 0,     O_DRAW,  1};
    vecs[11] = '{"redraw_last",    0, 0, 0, 0, 0, 14,    O_DRAW,  1};
    vecs[12] = '{"wait_again",     0, 0, 0, 0, 0, 0,     O_WAIT,  1};
    vecs[13] = '{"stop_and_tick",  0, 0, 1, 0, 1, 0,     O_IDLE,  1};
    vecs[14] = '{"tick_in_idle",   0, 0, 0, 0, 1, 0,     O_IDLE,  1};
    vecs[15] = '{"reset_clr_ov",   1, 0, 0, 0, 0, 0,     O_IDLE,  0};
    vecs[16] = '{"clear_5000",     0, 1, 0, 0, 0, 4999,  O_CLEAR, 0};
    vecs[17] = '{"reset_mid_clr",  1, 0, 0, 0, 0, 0,     O_IDLE,  0};

    repeat (2) tick_clk();

    for (int i = 0; i < NV; i++) begin
      logic [9:0] got, exp;
      apply(vecs[i]);
      got = outs();
      exp = {vecs[i].exp_out, vecs[i].exp_ov};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", vecs[i].name, got, exp);
      end
    end

    run_start(1'b1);
    run_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
